// File: rtl/remote_load_issue_ctrl_pkg.sv
// Shared types for the remote-load issue controller: load type and fence sequencing states.
package remote_load_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    RL_INT    = 2'd0,
    RL_FLOAT  = 2'd1,
    RL_ICACHE = 2'd2,
    RL_AMO    = 2'd3
  } rl_type_e;

  typedef enum logic [1:0] {
    RL_RUN,
    RL_DRAIN,
    RL_DONE
  } rl_fsm_e;

endpackage

// File: rtl/remote_load_issue_ctrl_if.sv
// Issue / return / fence handshake between the core's remote_req path and the load controller.
interface remote_load_issue_ctrl_if
  import remote_load_issue_ctrl_pkg::*;
#(
  parameter int unsigned reg_els_p = 32
);
  localparam int unsigned reg_id_width_lp = $clog2(reg_els_p);

  logic                       issue_v_i;
  rl_type_e                   issue_type_i;
  logic [reg_id_width_lp-1:0] issue_reg_id_i;
  logic                       issue_ready_o;

  logic                       ret_v_i;
  rl_type_e                   ret_type_i;
  logic [reg_id_width_lp-1:0] ret_reg_id_i;
  logic                       ret_yumi_o;

  logic                       fence_v_i;
  logic                       fence_done_o;

  modport master (
    output issue_v_i, issue_type_i, issue_reg_id_i,
    output ret_v_i, ret_type_i, ret_reg_id_i,
    output fence_v_i,
    input  issue_ready_o, ret_yumi_o, fence_done_o
  );

  modport slave (
    input  issue_v_i, issue_type_i, issue_reg_id_i,
    input  ret_v_i, ret_type_i, ret_reg_id_i,
    input  fence_v_i,
    output issue_ready_o, ret_yumi_o, fence_done_o
  );

endinterface

// File: rtl/remote_load_issue_ctrl_lat_stat.sv
// Load latency statistics: free-running timestamp, per-entry issue stamps, saturating sum and max.
module remote_load_lat_stat #(
  parameter  int unsigned entries_p    = 65,
  parameter  int unsigned lat_width_p  = 32,
  localparam int unsigned idx_width_lp = $clog2(entries_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_v_i,
  input  logic [idx_width_lp-1:0] start_idx_i,
  input  logic                    done_v_i,
  input  logic [idx_width_lp-1:0] done_idx_i,
  output logic [lat_width_p-1:0]  lat_sum_o,
  output logic [lat_width_p-1:0]  lat_max_o
);

  logic [lat_width_p-1:0] now;
  logic [lat_width_p-1:0] lat;
  logic [lat_width_p-1:0] stamp [entries_p];
  logic [lat_width_p:0]   sum_ext;

  // Modulo subtraction keeps latency correct across timestamp wrap.
  always_comb begin
    lat     = now - stamp[done_idx_i];
    sum_ext = {1'b0, lat_sum_o} + {1'b0, lat};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      now       <= '0;
      lat_sum_o <= '0;
      lat_max_o <= '0;
      for (int unsigned i = 0; i < entries_p; i++) stamp[i] <= '0;
    end else begin
      now <= now + lat_width_p'(1);
      if (start_v_i) stamp[start_idx_i] <= now;
      if (done_v_i) begin
        lat_sum_o <= sum_ext[lat_width_p] ? '1 : sum_ext[lat_width_p-1:0];
        if (lat > lat_max_o) lat_max_o <= lat;
      end
    end
  end

endmodule

// File: rtl/remote_load_issue_ctrl.sv
// Remote-load issue gate and pending-load scoreboard with fence sequencing.
// Optional latency statistics under `REMOTE_LOAD_ISSUE_CTRL_LAT_STAT_EN.
module remote_load_issue_ctrl
  import remote_load_issue_ctrl_pkg::*;
#(
  parameter  int unsigned reg_els_p      = 32,
  parameter  int unsigned max_out_p      = 16,
  parameter  int unsigned lat_width_p    = 32,
  localparam int unsigned count_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  remote_load_issue_ctrl_if.slave   bus,
  output logic [reg_els_p-1:0]      int_pending_o,
  output logic [reg_els_p-1:0]      float_pending_o,
  output logic                      icache_pending_o,
  output logic [count_width_lp-1:0] outstanding_o,
  output logic                      error_o,
  output logic [lat_width_p-1:0]    lat_sum_o,
  output logic [lat_width_p-1:0]    lat_max_o
);

  rl_fsm_e                   state;
  logic                      fence_done;
  logic                      issue_busy, ret_hit;
  logic                      issue_fire, ret_match, ret_miss;
  logic                      issue_is_int, issue_is_float, issue_is_icache;
  logic                      ret_is_int, ret_is_float, ret_is_icache;
  logic [reg_els_p-1:0]      issue_onehot, ret_onehot;
  logic [reg_els_p-1:0]      int_set, int_clr, float_set, float_clr;
  logic                      icache_set, icache_clr;
  logic [count_width_lp-1:0] count_next;

  // AMO shares the int scoreboard in both directions.
  always_comb begin
    issue_is_float  = (bus.issue_type_i == RL_FLOAT);
    issue_is_icache = (bus.issue_type_i == RL_ICACHE);
    issue_is_int    = !issue_is_float && !issue_is_icache;
    ret_is_float    = (bus.ret_type_i == RL_FLOAT);
    ret_is_icache   = (bus.ret_type_i == RL_ICACHE);
    ret_is_int      = !ret_is_float && !ret_is_icache;

    issue_busy = issue_is_icache ? icache_pending_o
               : issue_is_float  ? float_pending_o[bus.issue_reg_id_i]
               :                   int_pending_o[bus.issue_reg_id_i];
    ret_hit    = ret_is_icache   ? icache_pending_o
               : ret_is_float    ? float_pending_o[bus.ret_reg_id_i]
               :                   int_pending_o[bus.ret_reg_id_i];
  end

  assign bus.issue_ready_o = (state == RL_RUN)
                          && (outstanding_o < count_width_lp'(max_out_p))
                          && !issue_busy;
  assign bus.ret_yumi_o    = bus.ret_v_i;
  assign bus.fence_done_o  = fence_done;

  assign issue_fire = bus.issue_v_i && bus.issue_ready_o;
  assign ret_match  = bus.ret_v_i && ret_hit;
  assign ret_miss   = bus.ret_v_i && !ret_hit;

  always_comb begin
    issue_onehot                     = '0;
    issue_onehot[bus.issue_reg_id_i] = 1'b1;
    ret_onehot                       = '0;
    ret_onehot[bus.ret_reg_id_i]     = 1'b1;

    int_set    = {reg_els_p{issue_fire && issue_is_int}}   & issue_onehot;
    float_set  = {reg_els_p{issue_fire && issue_is_float}} & issue_onehot;
    icache_set = issue_fire && issue_is_icache;
    int_clr    = {reg_els_p{ret_match && ret_is_int}}      & ret_onehot;
    float_clr  = {reg_els_p{ret_match && ret_is_float}}    & ret_onehot;
    icache_clr = ret_match && ret_is_icache;
  end

  always_comb begin
    count_next = outstanding_o;
    if (issue_fire && !ret_match)      count_next = outstanding_o + count_width_lp'(1);
    else if (!issue_fire && ret_match) count_next = outstanding_o - count_width_lp'(1);
  end

  // An issue can only set a clear bit and a return only clears a set bit, so masks never collide.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      int_pending_o    <= '0;
      float_pending_o  <= '0;
      icache_pending_o <= 1'b0;
      outstanding_o    <= '0;
      error_o          <= 1'b0;
    end else begin
      int_pending_o    <= (int_pending_o | int_set) & ~int_clr;
      float_pending_o  <= (float_pending_o | float_set) & ~float_clr;
      icache_pending_o <= (icache_pending_o | icache_set) & ~icache_clr;
      outstanding_o    <= count_next;
      if (ret_miss) error_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= RL_RUN;
      fence_done <= 1'b0;
    end else begin
      fence_done <= 1'b0;
      case (state)
        RL_RUN:   if (bus.fence_v_i) state <= RL_DRAIN;
        RL_DRAIN: if (count_next == '0) begin
                    state      <= RL_DONE;
                    fence_done <= 1'b1;
                  end
        RL_DONE:  state <= RL_RUN;
        default:  state <= RL_RUN;
      endcase
    end
  end

`ifdef REMOTE_LOAD_ISSUE_CTRL_LAT_STAT_EN
  localparam int unsigned reg_id_width_lp = $clog2(reg_els_p);
  localparam int unsigned entries_lp      = 2 * reg_els_p + 1;
  localparam int unsigned idx_width_lp    = $clog2(entries_lp);

  // Stamp layout: int regs, then float regs, then the single icache slot.
  function automatic logic [idx_width_lp-1:0] entry_idx(rl_type_e t,
                                                        logic [reg_id_width_lp-1:0] id);
    case (t)
      RL_FLOAT:  return idx_width_lp'(reg_els_p) + idx_width_lp'(id);
      RL_ICACHE: return idx_width_lp'(2 * reg_els_p);
      default:   return idx_width_lp'(id);
    endcase
  endfunction

  remote_load_lat_stat #(
    .entries_p   (entries_lp),
    .lat_width_p (lat_width_p)
  ) lat_stat (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .start_v_i   (issue_fire),
    .start_idx_i (entry_idx(bus.issue_type_i, bus.issue_reg_id_i)),
    .done_v_i    (ret_match),
    .done_idx_i  (entry_idx(bus.ret_type_i, bus.ret_reg_id_i)),
    .lat_sum_o   (lat_sum_o),
    .lat_max_o   (lat_max_o)
  );
`else
  assign lat_sum_o = '0;
  assign lat_max_o = '0;
`endif

endmodule

// File: tb/tb_remote_load_issue_ctrl.sv
// Directed bench for remote_load_issue_ctrl: bitmap-level scoreboard model checked every cycle plus literal pins.
module tb_remote_load_issue_ctrl;
  import remote_load_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  remote_load_issue_ctrl_if #(.reg_els_p(32)) bus ();

  logic [31:0] int_pending, float_pending;
  logic        icache_pending, error;
  logic [4:0]  outstanding;
  logic [31:0] lat_sum, lat_max;

  remote_load_issue_ctrl #(
    .reg_els_p   (32),
    .max_out_p   (16),
    .lat_width_p (32)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .bus              (bus),
    .int_pending_o    (int_pending),
    .float_pending_o  (float_pending),
    .icache_pending_o (icache_pending),
    .outstanding_o    (outstanding),
    .error_o          (error),
    .lat_sum_o        (lat_sum),
    .lat_max_o        (lat_max)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: what is pending, whether a fence is in progress, and latency bookkeeping.
  logic [31:0] m_int   = '0;
  logic [31:0] m_float = '0;
  logic        m_ic    = 1'b0;
  logic        m_err   = 1'b0;
  logic        m_drain = 1'b0;
  logic        m_done  = 1'b0;
  longint      m_now   = 0;
  longint      m_sum   = 0;
  longint      m_max   = 0;
  longint      m_stamp [65];

  function automatic logic m_bit(rl_type_e t, int id);
    logic [4:0] i5;
    i5 = 5'(id);
    case (t)
      RL_FLOAT:  return m_float[i5];
      RL_ICACHE: return m_ic;
      default:   return m_int[i5];
    endcase
  endfunction

  task automatic m_set(rl_type_e t, int id, logic v);
    logic [4:0] i5;
    i5 = 5'(id);
    case (t)
      RL_FLOAT:  m_float[i5] = v;
      RL_ICACHE: m_ic = v;
      default:   m_int[i5] = v;
    endcase
  endtask

  function automatic int m_count();
    return $countones(m_int) + $countones(m_float) + (m_ic ? 1 : 0);
  endfunction

  function automatic logic m_ready();
    return !m_drain && !m_done && (m_count() < 16)
        && !m_bit(bus.issue_type_i, int'(bus.issue_reg_id_i));
  endfunction

  function automatic int e_idx(rl_type_e t, int id);
    case (t)
      RL_FLOAT:  return 32 + id;
      RL_ICACHE: return 64;
      default:   return id;
    endcase
  endfunction

  task automatic m_reset();
    m_int = '0; m_float = '0; m_ic = 1'b0; m_err = 1'b0;
    m_drain = 1'b0; m_done = 1'b0;
    m_now = 0; m_sum = 0; m_max = 0;
    for (int i = 0; i < 65; i++) m_stamp[i] = 0;
  endtask

  task automatic m_step();
    logic fire, hit;
    longint lat;
    int rid, iid;
    iid  = int'(bus.issue_reg_id_i);
    rid  = int'(bus.ret_reg_id_i);
    fire = bus.issue_v_i && m_ready();
    hit  = bus.ret_v_i && m_bit(bus.ret_type_i, rid);
    if (bus.ret_v_i && !hit) m_err = 1'b1;
    if (hit) begin
      lat   = (m_now - m_stamp[e_idx(bus.ret_type_i, rid)]) & 64'hFFFF_FFFF;
      m_sum = (m_sum + lat > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum + lat;
      if (lat > m_max) m_max = lat;
      m_set(bus.ret_type_i, rid, 1'b0);
    end
    if (fire) begin
      m_stamp[e_idx(bus.issue_type_i, iid)] = m_now;
      m_set(bus.issue_type_i, iid, 1'b1);
    end
    m_now++;
    if (m_done)       m_done = 1'b0;
    else if (m_drain) begin
      if (m_count() == 0) begin m_drain = 1'b0; m_done = 1'b1; end
    end
    else if (bus.fence_v_i) m_drain = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      check("ready",          64'(bus.issue_ready_o), 64'(m_ready()));
      check("yumi",           64'(bus.ret_yumi_o),    64'(bus.ret_v_i));
      check("int_pending",    64'(int_pending),       64'(m_int));
      check("float_pending",  64'(float_pending),     64'(m_float));
      check("icache_pending", 64'(icache_pending),    64'(m_ic));
      check("outstanding",    64'(outstanding),       64'(m_count()));
      check("error",          64'(error),             64'(m_err));
      check("fence_done",     64'(bus.fence_done_o),  64'(m_done));
`ifdef REMOTE_LOAD_ISSUE_CTRL_LAT_STAT_EN
      check("lat_sum",        64'(lat_sum),           64'(m_sum));
      check("lat_max",        64'(lat_max),           64'(m_max));
`else
      check("lat_sum",        64'(lat_sum),           64'd0);
      check("lat_max",        64'(lat_max),           64'd0);
`endif
      @(posedge clk);
      if (rst_n) m_step();
    end
  end

  task automatic drive(input logic iv, input rl_type_e it, input int iid,
                       input logic rv, input rl_type_e rt, input int rid);
    bus.issue_v_i      = iv;
    bus.issue_type_i   = it;
    bus.issue_reg_id_i = 5'(iid);
    bus.ret_v_i        = rv;
    bus.ret_type_i     = rt;
    bus.ret_reg_id_i   = 5'(rid);
  endtask

  task automatic idle();
    drive(1'b0, RL_INT, 0, 1'b0, RL_INT, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic [31:0] pi, pf;
    logic pc;
    pi = m_int; pf = m_float; pc = m_ic;
    for (int i = 0; i < 32; i++)
      if (pi[5'(i)]) begin drive(1'b0, RL_INT, 0, 1'b1, RL_INT, i); tick(); end
    for (int i = 0; i < 32; i++)
      if (pf[5'(i)]) begin drive(1'b0, RL_INT, 0, 1'b1, RL_FLOAT, i); tick(); end
    if (pc) begin drive(1'b0, RL_INT, 0, 1'b1, RL_ICACHE, 0); tick(); end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fence_v_i = 1'b0;
    idle();
    tick(); tick();
    check("rst_int",   64'(int_pending),      64'd0);
    check("rst_out",   64'(outstanding),      64'd0);
    check("rst_err",   64'(error),            64'd0);
    check("rst_done",  64'(bus.fence_done_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single INT load on reg 5, blocked duplicate, return + retry.
    drive(1'b1, RL_INT, 5, 1'b0, RL_INT, 0); #1;
    check("int5_ready", 64'(bus.issue_ready_o), 64'd1);
    tick(); idle();
    check("int5_pend", 64'(int_pending), 64'h20);
    check("int5_out",  64'(outstanding), 64'd1);
    drive(1'b1, RL_INT, 5, 1'b0, RL_INT, 0); #1;
    check("int5_dup_ready", 64'(bus.issue_ready_o), 64'd0);
    tick();
    drive(1'b1, RL_INT, 5, 1'b1, RL_INT, 5); #1;
    check("int5_ret_ready", 64'(bus.issue_ready_o), 64'd0);
    tick();
    check("int5_cleared", 64'(int_pending), 64'h0);
    check("int5_retry_ready", 64'(bus.issue_ready_o), 64'd1);
    tick(); idle();
    check("int5_reissued", 64'(int_pending), 64'h20);
    drain();

    // Fill to the outstanding limit.
    for (int i = 0; i < 16; i++) begin drive(1'b1, RL_INT, i, 1'b0, RL_INT, 0); tick(); end
    drive(1'b1, RL_INT, 20, 1'b0, RL_INT, 0); #1;
    check("full_out",   64'(outstanding),       64'd16);
    check("full_ready", 64'(bus.issue_ready_o), 64'd0);
    drive(1'b1, RL_INT, 20, 1'b1, RL_INT, 0); #1;
    check("full_ret_ready", 64'(bus.issue_ready_o), 64'd0);
    tick();
    check("full_ret_out", 64'(outstanding), 64'd15);
    drive(1'b1, RL_INT, 20, 1'b1, RL_INT, 1); #1;
    check("net_ready", 64'(bus.issue_ready_o), 64'd1);
    tick();
    check("net_out", 64'(outstanding), 64'd15);
    drive(1'b1, RL_INT, 21, 1'b0, RL_INT, 0); tick(); idle();
    check("refill_out", 64'(outstanding), 64'd16);
    drain();

    // Unmatched FLOAT return.
    drive(1'b0, RL_INT, 0, 1'b1, RL_FLOAT, 7); #1;
    check("miss_yumi", 64'(bus.ret_yumi_o), 64'd1);
    tick(); idle();
    check("miss_err", 64'(error),       64'd1);
    check("miss_out", 64'(outstanding), 64'd0);
    tick();
    check("miss_sticky", 64'(error), 64'd1);

    // Fence with three loads in flight.
    drive(1'b1, RL_INT,   1, 1'b0, RL_INT, 0); tick();
    drive(1'b1, RL_FLOAT, 2, 1'b0, RL_INT, 0); tick();
    drive(1'b1, RL_INT,   3, 1'b0, RL_INT, 0); tick();
    idle(); bus.fence_v_i = 1'b1; tick();
    drive(1'b1, RL_INT, 10, 1'b0, RL_INT, 0); #1;
    check("drain_ready", 64'(bus.issue_ready_o), 64'd0);
    drive(1'b0, RL_INT, 0, 1'b1, RL_INT, 1);   tick();
    drive(1'b0, RL_INT, 0, 1'b1, RL_FLOAT, 2); tick();
    check("drain_done_early", 64'(bus.fence_done_o), 64'd0);
    drive(1'b0, RL_INT, 0, 1'b1, RL_INT, 3);   tick();
    check("drain_done", 64'(bus.fence_done_o), 64'd1);
    idle(); bus.fence_v_i = 1'b0; tick();
    check("drain_done_pulse", 64'(bus.fence_done_o), 64'd0);

    // Fence with nothing pending completes on the second cycle.
    bus.fence_v_i = 1'b1; tick();
    check("fence0_c1", 64'(bus.fence_done_o), 64'd0);
    tick();
    check("fence0_c2", 64'(bus.fence_done_o), 64'd1);
    bus.fence_v_i = 1'b0; tick();

    // ICACHE single outstanding, INT/FLOAT reg 3 unaffected.
    drive(1'b1, RL_ICACHE, 0, 1'b0, RL_INT, 0); tick();
    check("ic_pend", 64'(icache_pending), 64'd1);
    drive(1'b1, RL_ICACHE, 0, 1'b0, RL_INT, 0); #1;
    check("ic_dup_ready", 64'(bus.issue_ready_o), 64'd0);
    drive(1'b1, RL_INT, 3, 1'b0, RL_INT, 0); #1;
    check("ic_int3_ready", 64'(bus.issue_ready_o), 64'd1);
    tick();
    drive(1'b1, RL_FLOAT, 3, 1'b0, RL_INT, 0); #1;
    check("ic_fl3_ready", 64'(bus.issue_ready_o), 64'd1);
    tick();
    check("ic_int3", 64'(int_pending),   64'h8);
    check("ic_fl3",  64'(float_pending), 64'h8);
    check("ic_out3", 64'(outstanding),   64'd3);
    drive(1'b1, RL_ICACHE, 0, 1'b1, RL_ICACHE, 0); #1;
    check("ic_ret_ready", 64'(bus.issue_ready_o), 64'd0);
    tick();
    check("ic_ret_pend", 64'(icache_pending), 64'd0);
    check("ic_ret_out",  64'(outstanding),    64'd2);
    drive(1'b1, RL_ICACHE, 0, 1'b0, RL_INT, 0); #1;
    check("ic_again_ready", 64'(bus.issue_ready_o), 64'd1);
    tick(); idle();
    drain();

    // Latency stats from a clean reset: returns at +10 and +25.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("lat_rst_err", 64'(error), 64'd0);
    drive(1'b1, RL_INT,   8, 1'b0, RL_INT, 0); tick();
    drive(1'b1, RL_FLOAT, 9, 1'b0, RL_INT, 0); tick();
    idle();
    for (int i = 0; i < 8; i++) tick();
    drive(1'b0, RL_INT, 0, 1'b1, RL_INT, 8); tick();
    idle();
    for (int i = 0; i < 15; i++) tick();
    drive(1'b0, RL_INT, 0, 1'b1, RL_FLOAT, 9); tick();
    idle();
`ifdef REMOTE_LOAD_ISSUE_CTRL_LAT_STAT_EN
    check("lat_sum_35", 64'(lat_sum), 64'd35);
    check("lat_max_25", 64'(lat_max), 64'd25);
`else
    check("lat_sum_off", 64'(lat_sum), 64'd0);
    check("lat_max_off", 64'(lat_max), 64'd0);
`endif
    check("lat_out", 64'(outstanding), 64'd0);

    // Asynchronous reset with loads in flight.
    drive(1'b1, RL_INT,   4, 1'b0, RL_INT, 0); tick();
    drive(1'b1, RL_FLOAT, 4, 1'b0, RL_INT, 0); tick();
    idle();
    check("pre_rst_out", 64'(outstanding), 64'd2);
    rst_n = 1'b0; #1;
    check("arst_int",   64'(int_pending),   64'd0);
    check("arst_float", 64'(float_pending), 64'd0);
    check("arst_out",   64'(outstanding),   64'd0);
    check("arst_sum",   64'(lat_sum),       64'd0);
    check("arst_max",   64'(lat_max),       64'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, RL_INT, 0, 1'b1, RL_INT, 4); tick();
    idle();
    check("post_rst_err", 64'(error),       64'd1);
    check("post_rst_out", 64'(outstanding), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
